mc_datapath_gen: RTL and testbench

//   Parametrised next-generation multicycle ARM datapath: PC, IR, data, A, WriteData and ALUOut registers, regfile, extender, ALU.

---
 rtl/mcdp_pkg.sv | 45 ++++
 rtl/mc_datapath_gen_mul.sv | 74 +++++++
 rtl/mc_datapath_gen.sv | 171 +++++++++++++++++
 tb/tb_mc_datapath_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdp_pkg.sv
// Shared encodings for the multicycle datapath
// and its iterative multiplier.
package mcdp_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10,
    RES_MUL    = 2'b11
  } res_e;

  typedef enum logic [1:0] {
    IMM_8  = 2'b00,
    IMM_12 = 2'b01,
    IMM_BR = 2'b10
  } imm_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mc_datapath_gen_mul.sv
// Iterative shift-add multiplier retiring MUL_K
// multiplier bits per cycle, start/busy/done handshake.
module mc_mul_iter
  import mcdp_pkg::*;
#(
  parameter int MUL_K = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] product
);

  localparam int STEPS = WORD / MUL_K;

  mul_state_e state, state_nx;

  logic [WORD-1:0] mcand, mplr, acc;
  logic [WORD-1:0] partial, acc_nx, prod_q;
  logic [5:0]      cnt;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_K; i++) begin
      if (mplr[i]) partial = partial + (mcand << i);
    end
    acc_nx = acc + partial;
  end

  assign busy = (state == MUL_RUN);
  assign done = busy && (cnt == 6'(STEPS - 1));
  // final sum is visible in the done cycle itself
  assign product = done ? acc_nx : prod_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      MUL_IDLE: if (start) state_nx = MUL_RUN;
      MUL_RUN:  if (done)  state_nx = MUL_IDLE;
      default:  state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MUL_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else if (!busy && start) begin
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (busy) begin
      acc   <= acc_nx;
      mcand <= mcand << MUL_K;
      mplr  <= mplr >> MUL_K;
      cnt   <= cnt + 6'd1;
      if (done) prod_q <= acc_nx;
    end
  end

endmodule

// File: rtl/mc_datapath_gen.sv
// Multicycle ARM datapath with sized regfile and MUL unit.
// Define MCDP_SHIFTER_EN to shift the register SrcB operand.
module mc_datapath_gen
  import mcdp_pkg::*;
#(
  parameter int          NREGS    = 16,
  parameter int          MUL_K    = 1,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [WORD-1:0] Adr,
  output logic [WORD-1:0] WriteData,
  input  logic [WORD-1:0] ReadData,
  output logic [WORD-1:0] Instr,
  output logic [3:0]      ALUFlags,
  input  logic            PCWrite,
  input  logic            RegWrite,
  input  logic            IRWrite,
  input  logic            AdrSrc,
  input  logic [1:0]      RegSrc,
  input  logic            ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [1:0]      ResultSrc,
  input  logic [1:0]      ImmSrc,
  input  logic [1:0]      ALUControl,
  input  logic            MulStart,
  output logic            MulBusy,
  output logic            MulDone
);

  localparam int            IW  = $clog2(NREGS);
  localparam logic [IW-1:0] TOP = IW'(NREGS - 1);

  logic [WORD-1:0] pc, ir, data, a_reg, wd_reg, alu_out;
  logic [WORD-1:0] rd1, rd2, result, src_a, src_b;
  logic [WORD-1:0] shifted, ext_imm, alu_res, mul_out;
  logic [WORD-1:0] b_in;
  logic [WORD:0]   sum;
  logic            carry, ovf, mul_done;
  logic [IW-1:0]   ra1, ra2, wa;
  logic [WORD-1:0] rf [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_RESET;
      ir      <= '0;
      data    <= '0;
      a_reg   <= '0;
      wd_reg  <= '0;
      alu_out <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) ir <= ReadData;
      data    <= ReadData;
      a_reg   <= rd1;
      wd_reg  <= rd2;
      alu_out <= alu_res;
    end
  end

  assign ra1 = RegSrc[0] ? TOP : ir[16 +: IW];
  assign ra2 = RegSrc[1] ? ir[12 +: IW] : ir[0 +: IW];
  // MUL writes its product to Rd in bits 19:16
  assign wa  = mul_done ? ir[16 +: IW] : ir[12 +: IW];

  always_ff @(posedge clk) begin
    if (RegWrite && wa != TOP) rf[wa] <= result;
  end

  assign rd1 = (ra1 == TOP) ? result : rf[ra1];
  assign rd2 = (ra2 == TOP) ? result : rf[ra2];

  always_comb begin
    ext_imm = '0;
    case (imm_e'(ImmSrc))
      IMM_8:   ext_imm = {24'b0, ir[7:0]};
      IMM_12:  ext_imm = {20'b0, ir[11:0]};
      IMM_BR:  ext_imm = {{6{ir[23]}}, ir[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

`ifdef MCDP_SHIFTER_EN
  logic [4:0] shamt;
  assign shamt = ir[11:7];

  always_comb begin
    shifted = wd_reg;
    if (shamt != 5'd0) begin
      case (shift_e'(ir[6:5]))
        SH_LSL: shifted = wd_reg << shamt;
        SH_LSR: shifted = wd_reg >> shamt;
        SH_ASR: shifted = WORD'($signed(wd_reg) >>> shamt);
        SH_ROR: shifted = (wd_reg >> shamt)
                        | (wd_reg << (6'd32 - {1'b0, shamt}));
        default: shifted = wd_reg;
      endcase
    end
  end
`else
  assign shifted = wd_reg;
`endif

  assign src_a = ALUSrcA ? pc : a_reg;

  always_comb begin
    src_b = '0;
    case (srcb_e'(ALUSrcB))
      SRCB_REG:  src_b = shifted;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = 32'd4;
      default:   src_b = '0;
    endcase
  end

  always_comb begin
    b_in    = ALUControl[0] ? ~src_b : src_b;
    sum     = {1'b0, src_a} + {1'b0, b_in}
            + {{WORD{1'b0}}, ALUControl[0]};
    alu_res = sum[WORD-1:0];
    carry   = sum[WORD];
    ovf     = (src_a[WORD-1] == b_in[WORD-1])
           && (sum[WORD-1] != src_a[WORD-1]);
    case (aluop_e'(ALUControl))
      ALU_AND: begin
        alu_res = src_a & src_b;
        carry   = 1'b0;
        ovf     = 1'b0;
      end
      ALU_ORR: begin
        alu_res = src_a | src_b;
        carry   = 1'b0;
        ovf     = 1'b0;
      end
      default: ;
    endcase
  end

  assign ALUFlags = {alu_res[WORD-1], alu_res == '0, carry, ovf};

  always_comb begin
    result = alu_out;
    case (res_e'(ResultSrc))
      RES_ALUOUT: result = alu_out;
      RES_DATA:   result = data;
      RES_ALU:    result = alu_res;
      RES_MUL:    result = mul_out;
      default:    result = alu_out;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = wd_reg;
  assign Instr     = ir;
  assign MulDone   = mul_done;

  mc_mul_iter #(
    .MUL_K(MUL_K)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (MulStart),
    .a      (src_a),
    .b      (src_b),
    .busy   (MulBusy),
    .done   (mul_done),
    .product(mul_out)
  );

endmodule

// File: tb/tb_mc_datapath_gen.sv
// Directed bench: two datapaths (MUL_K=1 and MUL_K=4)
// sharing every control input.
module tb_mc_datapath_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ReadData;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic        ALUSrcA, MulStart;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  logic [31:0] adr1, wd1, instr1, adr4, wd4, instr4;
  logic [3:0]  flags1, flags4;
  logic        busy1, done1, busy4, done4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_datapath_gen #(
    .NREGS(16), .MUL_K(1), .PC_RESET(32'h100)
  ) u_k1 (
    .clk(clk), .reset(reset), .Adr(adr1), .WriteData(wd1),
    .ReadData(ReadData), .Instr(instr1), .ALUFlags(flags1),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .MulStart(MulStart),
    .MulBusy(busy1), .MulDone(done1)
  );

  mc_datapath_gen #(
    .NREGS(16), .MUL_K(4), .PC_RESET(32'h100)
  ) u_k4 (
    .clk(clk), .reset(reset), .Adr(adr4), .WriteData(wd4),
    .ReadData(ReadData), .Instr(instr4), .ALUFlags(flags4),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .MulStart(MulStart),
    .MulBusy(busy4), .MulDone(done4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl;
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
    ALUSrcA = 0; MulStart = 0; RegSrc = 0; ALUSrcB = 0;
    ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
  endtask

  task automatic test_reset;
    idle_ctl();
    ReadData = 32'h0;
    reset = 1;
    step();
    step();
    checks++;
    if (adr1 !== 32'h100) begin
      failures++;
      $display("FAIL reset_adr1 got %h exp %h", adr1, 32'h100);
    end
    checks++;
    if (adr4 !== 32'h100) begin
      failures++;
      $display("FAIL reset_adr4 got %h exp %h", adr4, 32'h100);
    end
    checks++;
    if (instr1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_instr got %h exp 0", instr1);
    end
    checks++;
    if (wd1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_wd got %h exp 0", wd1);
    end
    checks++;
    if ({busy1, done1, busy4, done4} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mul got %b exp 0000",
               {busy1, done1, busy4, done4});
    end
    checks++;
    if (flags1 !== 4'b0100) begin
      failures++;
      $display("FAIL reset_flags got %b exp 0100", flags1);
    end
    reset = 0;
    step();
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_next got %b exp 0", busy1);
    end
  endtask

  task automatic test_fetch;
    ReadData = 32'hE281_1005;
    IRWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10;
    ResultSrc = 2'b10; PCWrite = 1;
    step();
    idle_ctl();
    #1;
    checks++;
    if (instr1 !== 32'hE281_1005) begin
      failures++;
      $display("FAIL fetch_instr got %h exp %h",
               instr1, 32'hE281_1005);
    end
    checks++;
    if (adr1 !== 32'h104) begin
      failures++;
      $display("FAIL fetch_pc got %h exp %h", adr1, 32'h104);
    end
  endtask

  task automatic test_alu;
    logic [31:0] exp_r [5];
    logic [3:0]  exp_f [5];
    logic [1:0]  imm_t [5];
    logic [1:0]  srcb_t [5];
    logic [1:0]  op_t [5];
    // PC=0x104, Instr=0xE2811005
    exp_r[0] = 32'h0000_0109; exp_f[0] = 4'b0000;
    imm_t[0] = 2'b00; srcb_t[0] = 2'b01; op_t[0] = 2'b00;
    exp_r[1] = 32'hFE04_4118; exp_f[1] = 4'b1000;
    imm_t[1] = 2'b10; srcb_t[1] = 2'b01; op_t[1] = 2'b00;
    exp_r[2] = 32'h0000_0100; exp_f[2] = 4'b0010;
    imm_t[2] = 2'b00; srcb_t[2] = 2'b10; op_t[2] = 2'b01;
    exp_r[3] = 32'h01FB_C0F0; exp_f[3] = 4'b0000;
    imm_t[3] = 2'b10; srcb_t[3] = 2'b01; op_t[3] = 2'b01;
    exp_r[4] = 32'h0000_0004; exp_f[4] = 4'b0000;
    imm_t[4] = 2'b01; srcb_t[4] = 2'b01; op_t[4] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      idle_ctl();
      ALUSrcA = 1; AdrSrc = 1; ResultSrc = 2'b10;
      ImmSrc = imm_t[i]; ALUSrcB = srcb_t[i];
      ALUControl = op_t[i];
      #1;
      checks++;
      if (adr1 !== exp_r[i] || flags1 !== exp_f[i]) begin
        failures++;
        $display("FAIL alu_%0d got %h/%b exp %h/%b",
                 i, adr1, flags1, exp_r[i], exp_f[i]);
      end
    end
    ALUControl = 2'b11;
    ImmSrc = 2'b00;
    #1;
    checks++;
    if (adr1 !== 32'h105 || flags1 !== 4'b0000) begin
      failures++;
      $display("FAIL alu_orr got %h/%b exp %h/0000",
               adr1, flags1, 32'h105);
    end
    idle_ctl();
  endtask

  task automatic test_mul_k1;
    int d1 = 0, d4 = 0, b1 = 0, b4 = 0, n1 = 0, n4 = 0;
    idle_ctl();
    ReadData = 32'd7;
    step();
    ResultSrc = 2'b01; PCWrite = 1;
    ReadData = 32'd6; IRWrite = 1;
    step();
    idle_ctl();
    ALUSrcA = 1; ALUSrcB = 2'b01; MulStart = 1;
    step();
    idle_ctl();
    ResultSrc = 2'b11; AdrSrc = 1;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (busy1) b1++;
      if (busy4) b4++;
      if (done1) begin
        d1 = c; n1++;
        checks++;
        if (adr1 !== 32'd42) begin
          failures++;
          $display("FAIL k1_prod got %h exp %h", adr1, 32'd42);
        end
      end
      if (done4) begin
        d4 = c; n4++;
        checks++;
        if (adr4 !== 32'd42) begin
          failures++;
          $display("FAIL k4_prod got %h exp %h", adr4, 32'd42);
        end
      end
      step();
    end
    checks++;
    if (d1 != 32 || b1 != 32 || n1 != 1) begin
      failures++;
      $display("FAIL k1_timing got done=%0d busy=%0d n=%0d exp 32/32/1",
               d1, b1, n1);
    end
    checks++;
    if (d4 != 8 || b4 != 8 || n4 != 1) begin
      failures++;
      $display("FAIL k4_timing got done=%0d busy=%0d n=%0d exp 8/8/1",
               d4, b4, n4);
    end
    checks++;
    if (adr1 !== 32'd42 || adr4 !== 32'd42) begin
      failures++;
      $display("FAIL mul_hold got %h/%h exp 42", adr1, adr4);
    end
  endtask

  task automatic test_mul_k4;
    int d1 = 0, d4 = 0, n1 = 0, n4 = 0;
    idle_ctl();
    ReadData = 32'h0000_1000; IRWrite = 1;
    step();
    idle_ctl();
    ReadData = 32'hFFFF_FFFF;
    step();
    ResultSrc = 2'b01; PCWrite = 1; RegWrite = 1;
    step();
    idle_ctl();
    RegSrc = 2'b10;
    step();
    ALUSrcA = 1; ALUSrcB = 2'b00; MulStart = 1;
    step();
    idle_ctl();
    RegSrc = 2'b10; ResultSrc = 2'b11; AdrSrc = 1;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (c == 1) begin
        checks++;
        if (adr4 !== 32'd42) begin
          failures++;
          $display("FAIL k4_prev_hold got %h exp 42", adr4);
        end
      end
      if (done1) begin
        d1 = c; n1++;
        checks++;
        if (adr1 !== 32'h1) begin
          failures++;
          $display("FAIL k1_ovf_prod got %h exp 1", adr1);
        end
      end
      if (done4) begin
        d4 = c; n4++;
        checks++;
        if (adr4 !== 32'h1) begin
          failures++;
          $display("FAIL k4_ovf_prod got %h exp 1", adr4);
        end
      end
      // restart attempts mid-run and in the done cycle
      if (c == 3 || c == 8) begin
        MulStart = 1; ALUSrcA = 1; ALUSrcB = 2'b10;
      end
      step();
      MulStart = 0; ALUSrcA = 0; ALUSrcB = 2'b00;
    end
    checks++;
    if (d4 != 8 || n4 != 1 || d1 != 32 || n1 != 1) begin
      failures++;
      $display("FAIL ovf_timing got d4=%0d n4=%0d d1=%0d n1=%0d",
               d4, n4, d1, n1);
    end
    checks++;
    if (busy4 !== 1'b0 || adr4 !== 32'h1) begin
      failures++;
      $display("FAIL k4_after got busy=%b out=%h exp 0/1",
               busy4, adr4);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    idle_ctl();
    ALUSrcA = 1; ALUSrcB = 2'b10; MulStart = 1;
    step();
    idle_ctl();
    ResultSrc = 2'b11; AdrSrc = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (done1 || done4) bad++;
      if (c == 5) reset = 1;
      step();
    end
    checks++;
    if ({busy1, busy4, done1, done4} !== 4'b0) begin
      failures++;
      $display("FAIL rst_mid_flags got %b exp 0000",
               {busy1, busy4, done1, done4});
    end
    checks++;
    if (adr1 !== 32'h0 || adr4 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_out got %h/%h exp 0", adr1, adr4);
    end
    reset = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done1 || done4 || busy1 || busy4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_nodone got %0d events exp 0", bad);
    end
  endtask

  task automatic test_shifter;
    logic [31:0] exp_r;
`ifdef MCDP_SHIFTER_EN
    exp_r = 32'hF800_0000;
`else
    exp_r = 32'h8000_0000;
`endif
    idle_ctl();
    ReadData = 32'h0000_2240; IRWrite = 1;
    step();
    idle_ctl();
    ReadData = 32'h8000_0000;
    step();
    ResultSrc = 2'b01; RegWrite = 1;
    step();
    idle_ctl();
    RegSrc = 2'b10;
    ReadData = 32'h0;
    step();
    ResultSrc = 2'b01; PCWrite = 1;
    step();
    idle_ctl();
    RegSrc = 2'b10; ALUSrcA = 1; ALUSrcB = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    #1;
    checks++;
    if (adr1 !== exp_r) begin
      failures++;
      $display("FAIL shift_result got %h exp %h", adr1, exp_r);
    end
    checks++;
    if (flags1 !== 4'b1000) begin
      failures++;
      $display("FAIL shift_flags got %b exp 1000", flags1);
    end
    checks++;
    if (wd1 !== 32'h8000_0000) begin
      failures++;
      $display("FAIL shift_wd got %h exp %h", wd1, 32'h8000_0000);
    end
    idle_ctl();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_alu();
    test_mul_k1();
    test_mul_k4();
    test_reset_mid();
    test_shifter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
